clock_ctrl: RTL and testbench
=============================

Name: clock_ctrl

Overview:
- Sequencing and time-set controller for a 24-hour BCD clock built from three BCD digit-pair counters:
  - seconds, 00–59
  - minutes, 00–59
  - hours, 00–23
- Derives a 1 Hz tick from the system clock.
- Generates single-cycle count enables with carry chaining.
- Runs a run/set state machine that lets two debounced buttons adjust hours and minutes.
- Sits between the button/debounce logic and the counter datapath; the display block consumes MODE and BLINK.

Parameters:
- DIV, 50000000: system clock cycles per tick; minimum 4.
- TIMEOUT, 10: ticks without a button press before set mode returns to RUN; minimum 1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- BTN_MODE  input  1  debounced single-cycle pulse: advance mode.
- BTN_INC  input  1  debounced single-cycle pulse: increment the selected field.
- SEC_CNT  input  8  BCD seconds {tens, units} from the seconds counter.
- MIN_CNT  input  8  BCD minutes from the minutes counter.
- HR_CNT  input  8  BCD hours from the hours counter.
- CE_SEC  output  1  count enable to the seconds counter.
- CE_MIN  output  1  count enable to the minutes counter.
- CE_HR  output  1  count enable to the hours counter.
- SEC_CLR  output  1  one-cycle clear request to the seconds counter.
- MODE  output  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 never driven.
- BLINK  output  1  display blink phase for the selected field.

Behaviour:
- Clock and reset
  - One clock, CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
  - Reset values: prescaler = 0, state = RUN, MODE = 00, all CE_* = 0, SEC_CLR = 0, BLINK = 0, timeout counter = 0.
  - RST asserted mid-operation overrides everything in the same edge, including pending enables.
- Prescaler
  - Counts 0 .. DIV-1 in every state and wraps to 0.
  - Internal tick = 1 in the cycle where the count equals DIV-1.
  - The count is forced to 0 on exit from SET_MIN to RUN.
- Output timing
  - All outputs are registered.
  - CE_* assert in the cycle after the tick and last exactly 1 cycle.
- RUN state
  - On tick: CE_SEC = 1.
  - CE_MIN = 1 iff SEC_CNT == 8'h59 at the tick cycle.
  - CE_HR = 1 iff SEC_CNT == 8'h59 and MIN_CNT == 8'h59 at the tick cycle.
  - Hours wrap 23→00 inside the hours counter; the controller does no hour-wrap arithmetic.
  - BLINK = 0.
  - BTN_INC is ignored.
  - BTN_MODE → SET_HR; timeout counter cleared.
- SET_HR state
  - Tick-driven CE_SEC, CE_MIN and CE_HR are suppressed; time is frozen.
  - BTN_INC → CE_HR = 1 next cycle, one cycle. No carry to or from other fields.
  - BTN_MODE → SET_MIN.
- SET_MIN state
  - BTN_INC → CE_MIN = 1 next cycle only. A 59→00 wrap does not propagate to hours.
  - BTN_MODE → RUN, with SEC_CLR = 1 for one cycle next cycle and the prescaler zeroed, so counting restarts at ss = 00 with a full tick period.
- Set-mode common rules
  - BLINK toggles on every tick.
  - BLINK is forced to 1 on entry to a set state and on every BTN_INC, so the field stays visible while it is edited.
  - The timeout counter increments on each tick and clears on any button pulse.
  - When the counter reaches TIMEOUT → RUN, with the same SEC_CLR and prescaler-zero actions as a BTN_MODE exit from SET_MIN.
  - The timeout counter width is sufficient for TIMEOUT.
- Simultaneous events
  - BTN_MODE and BTN_INC in the same cycle: BTN_MODE wins and BTN_INC is dropped.
  - Tick and a button in the same cycle in a set state: the button is processed, and the tick only advances BLINK and timeout, except that a tick-triggered timeout is cancelled by the button.
  - BTN_INC held high for N consecutive cycles yields N CE pulses.
  - Pulses in the cycle after a state transition are evaluated against the new state.
- Never more than one of CE_SEC/CE_MIN/CE_HR is asserted from a button; RUN carries may assert up to all three in the same cycle.

Test Plan:
- Reset and free run
  - Stimulus: DIV = 4, RST for 2 cycles, then run 8 cycles.
  - Required response: all outputs are 0 at reset; CE_SEC pulses every 4 cycles, 1 cycle wide, first pulse 4 cycles after release; MODE = 00.
- Carry chain
  - Stimulus: SEC = 59, MIN = 59, HR = 23, then a tick.
  - Required response: CE_SEC, CE_MIN and CE_HR all pulse in the same cycle.
  - Stimulus: SEC = 59, MIN = 12.
  - Required response: only CE_SEC and CE_MIN pulse.
- Set hours
  - Stimulus: BTN_MODE, then 3× BTN_INC, with ticks occurring.
  - Required response: MODE = 01; exactly 3 CE_HR pulses; no CE_SEC during SET_HR; BLINK toggles per tick.
- Set minutes and exit
  - Stimulus: from SET_HR, BTN_MODE, BTN_INC with MIN = 59, then BTN_MODE.
  - Required response: MODE = 10; CE_MIN pulses once with no CE_HR; MODE = 00; SEC_CLR pulses once; the next CE_SEC comes exactly DIV cycles later.
- Simultaneous events and timeout
  - Stimulus: BTN_MODE and BTN_INC in the same cycle in RUN.
  - Required response: MODE = 01 and no CE_HR.
  - Stimulus: TIMEOUT = 3 with no presses.
  - Required response: return to RUN after the 3rd tick, with a SEC_CLR pulse.
- Reset mid-set
  - Stimulus: RST asserted in SET_MIN coincident with BTN_INC.
  - Required response: no CE_MIN; MODE = 00; prescaler restarts from 0.

Source files
------------

// File: rtl/clock_ctrl.sv
// Run/set sequencer for a 24-hour BCD clock: 1 Hz prescaler, carry-chained count
// enables, and a two-button hour/minute set state machine with inactivity timeout.
module clock_ctrl #(
    parameter int DIV     = 50000000,
    parameter int TIMEOUT = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    input  logic [7:0] SEC_CNT,
    input  logic [7:0] MIN_CNT,
    input  logic [7:0] HR_CNT,
    output logic       CE_SEC,
    output logic       CE_MIN,
    output logic       CE_HR,
    output logic       SEC_CLR,
    output logic [1:0] MODE,
    output logic       BLINK
);

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SET_HR  = 2'b01;
    localparam logic [1:0] SET_MIN = 2'b10;

    localparam int PW = $clog2(DIV);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [PW-1:0] pre;
    logic [TW-1:0] to_cnt;
    logic          tick;
    logic          to_hit;
    logic          sec59;
    logic          min59;
    logic          unused_hr;

    // Hour wrap lives in the hours counter; the value is not needed here.
    assign unused_hr = ^HR_CNT;

    assign tick   = (pre == PW'(DIV - 1));
    assign to_hit = (to_cnt == TW'(TIMEOUT - 1));
    assign sec59  = (SEC_CNT == 8'h59);
    assign min59  = (MIN_CNT == 8'h59);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre     <= '0;
            to_cnt  <= '0;
            MODE    <= RUN;
            CE_SEC  <= 1'b0;
            CE_MIN  <= 1'b0;
            CE_HR   <= 1'b0;
            SEC_CLR <= 1'b0;
            BLINK   <= 1'b0;
        end else begin
            CE_SEC  <= 1'b0;
            CE_MIN  <= 1'b0;
            CE_HR   <= 1'b0;
            SEC_CLR <= 1'b0;
            pre     <= tick ? '0 : pre + 1'b1;

            case (MODE)
                RUN: begin
                    BLINK <= 1'b0;
                    if (tick) begin
                        CE_SEC <= 1'b1;
                        CE_MIN <= sec59;
                        CE_HR  <= sec59 & min59;
                    end
                    if (BTN_MODE) begin
                        MODE   <= SET_HR;
                        to_cnt <= '0;
                        BLINK  <= 1'b1;
                    end
                end
                SET_HR, SET_MIN: begin
                    // A button pulse takes priority over a coincident tick and cancels its timeout.
                    if (BTN_MODE || BTN_INC) begin
                        to_cnt <= '0;
                        BLINK  <= 1'b1;
                        if (BTN_MODE) begin
                            if (MODE == SET_HR) begin
                                MODE <= SET_MIN;
                            end else begin
                                MODE    <= RUN;
                                SEC_CLR <= 1'b1;
                                pre     <= '0;
                                BLINK   <= 1'b0;
                            end
                        end else if (MODE == SET_HR) begin
                            CE_HR <= 1'b1;
                        end else begin
                            CE_MIN <= 1'b1;
                        end
                    end else if (tick) begin
                        BLINK <= ~BLINK;
                        if (to_hit) begin
                            MODE    <= RUN;
                            SEC_CLR <= 1'b1;
                            pre     <= '0;
                            BLINK   <= 1'b0;
                            to_cnt  <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                default: MODE <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed vector table, multi-cycle corner sequences,
// then randomized traffic against an arithmetic reference model.
module tb_clock_ctrl;

    localparam int DIV     = 4;
    localparam int TIMEOUT = 3;

    logic       CLK = 1'b0;
    logic       RST, BTN_MODE, BTN_INC;
    logic [7:0] SEC_CNT, MIN_CNT, HR_CNT;
    logic       CE_SEC, CE_MIN, CE_HR, SEC_CLR, BLINK;
    logic [1:0] MODE;

    int total = 0;
    int bad   = 0;

    clock_ctrl #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
        .SEC_CNT(SEC_CNT), .MIN_CNT(MIN_CNT), .HR_CNT(HR_CNT),
        .CE_SEC(CE_SEC), .CE_MIN(CE_MIN), .CE_HR(CE_HR),
        .SEC_CLR(SEC_CLR), .MODE(MODE), .BLINK(BLINK)
    );

    always #5 CLK = ~CLK;

    // Reference model: cycles elapsed in the current tick period, mode as 0/1/2,
    // ticks since the last button press, and the blink phase.
    int         m_phase = 0;
    int         m_mode  = 0;
    int         m_idle  = 0;
    bit         m_blink = 0;
    logic [6:0] m_out   = '0;

    function automatic logic [6:0] dut_vec();
        return {CE_SEC, CE_MIN, CE_HR, SEC_CLR, MODE, BLINK};
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, bm, bi, input logic [7:0] s, m);
        bit ts, tm, th, clr, tick;
        ts = 0; tm = 0; th = 0; clr = 0;
        if (r) begin
            m_phase = 0; m_mode = 0; m_idle = 0; m_blink = 0;
        end else begin
            tick    = (m_phase == DIV - 1);
            m_phase = (m_phase + 1) % DIV;
            if (m_mode == 0) begin
                m_blink = 0;
                if (tick) begin
                    ts = 1;
                    tm = (s == 8'h59);
                    th = (s == 8'h59) && (m == 8'h59);
                end
                if (bm) begin
                    m_mode = 1; m_idle = 0; m_blink = 1;
                end
            end else if (bm || bi) begin
                m_idle  = 0;
                m_blink = 1;
                if (bm) begin
                    if (m_mode == 1) m_mode = 2;
                    else begin
                        m_mode = 0; clr = 1; m_phase = 0; m_blink = 0;
                    end
                end else if (m_mode == 1) th = 1;
                else tm = 1;
            end else if (tick) begin
                m_idle++;
                m_blink = !m_blink;
                if (m_idle >= TIMEOUT) begin
                    m_mode = 0; m_idle = 0; clr = 1; m_phase = 0; m_blink = 0;
                end
            end
        end
        m_out = {ts, tm, th, clr, 2'(m_mode), m_blink};
    endtask

    task automatic cyc(input bit r, bm, bi, input logic [7:0] s, m);
        RST = r; BTN_MODE = bm; BTN_INC = bi; SEC_CNT = s; MIN_CNT = m; HR_CNT = 8'h23;
        model(r, bm, bi, s, m);
        @(posedge CLK);
        #1;
        chk("model", dut_vec(), m_out);
    endtask

    // Cycles until CE_SEC appears; -1 if the bound expires.
    task automatic wait_ce_sec(output int n);
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0, 8'h00, 8'h00);
            if (CE_SEC) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [7:0] rnd_bcd60();
        logic [3:0] t, u;
        t = 4'($urandom_range(0, 5));
        u = 4'($urandom_range(0, 9));
        return {t, u};
    endfunction

    typedef struct {
        bit         rst, bm, bi;
        logic [7:0] sec, min;
        logic [6:0] exp;  // {ce_sec, ce_min, ce_hr, sec_clr, mode[1:0], blink}
    } vec_t;

    vec_t tbl[15];

    initial begin
        int n, hr_cnt, sec_cnt;
        bit seen;

        tbl[0]  = '{1, 0, 0, 8'h00, 8'h00, 7'b0000000};
        tbl[1]  = '{1, 0, 0, 8'h00, 8'h00, 7'b0000000};
        tbl[2]  = '{0, 0, 0, 8'h00, 8'h00, 7'b0000000};
        tbl[3]  = '{0, 0, 0, 8'h00, 8'h00, 7'b0000000};
        tbl[4]  = '{0, 0, 0, 8'h00, 8'h00, 7'b0000000};
        tbl[5]  = '{0, 0, 0, 8'h00, 8'h00, 7'b1000000};
        tbl[6]  = '{0, 0, 0, 8'h59, 8'h59, 7'b0000000};
        tbl[7]  = '{0, 0, 0, 8'h59, 8'h59, 7'b0000000};
        tbl[8]  = '{0, 0, 0, 8'h59, 8'h59, 7'b0000000};
        tbl[9]  = '{0, 0, 0, 8'h59, 8'h59, 7'b1110000};
        tbl[10] = '{0, 0, 0, 8'h59, 8'h12, 7'b0000000};
        tbl[11] = '{0, 0, 0, 8'h59, 8'h12, 7'b0000000};
        tbl[12] = '{0, 0, 0, 8'h59, 8'h12, 7'b0000000};
        tbl[13] = '{0, 0, 0, 8'h59, 8'h12, 7'b1100000};
        tbl[14] = '{0, 1, 1, 8'h00, 8'h00, 7'b0000011};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].bm, tbl[i].bi, tbl[i].sec, tbl[i].min);
            chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Set hours: three increments spread across ticks.
        hr_cnt = 0; sec_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, (i % 4) == 0, 8'h59, 8'h59);
            hr_cnt  += int'(CE_HR);
            sec_cnt += int'(CE_SEC);
        end
        chk("set_hr_pulses", 7'(hr_cnt), 7'd3);
        chk("set_hr_no_sec", 7'(sec_cnt), 7'd0);
        chk("set_hr_mode", {5'b0, MODE}, 7'd1);

        // Set minutes with MIN = 59, then exit.
        cyc(0, 1, 0, 8'h00, 8'h59);
        chk("set_min_mode", {5'b0, MODE}, 7'd2);
        cyc(0, 0, 1, 8'h00, 8'h59);
        chk("set_min_ce", {5'b0, CE_MIN, CE_HR}, 7'b0000010);
        cyc(0, 1, 0, 8'h00, 8'h59);
        chk("exit_clr", {4'b0, SEC_CLR, MODE}, 7'b0000100);
        wait_ce_sec(n);
        chk("exit_restart", 7'(n), 7'(DIV));

        // Timeout: no presses in SET_HR returns to RUN with a clear pulse.
        cyc(0, 1, 0, 8'h00, 8'h00);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 8'h00, 8'h00);
            if (MODE == 2'b00) begin
                seen = 1;
                chk("timeout_clr", {6'b0, SEC_CLR}, 7'd1);
                break;
            end
        end
        chk("timeout_seen", {6'b0, seen}, 7'd1);

        // Reset in SET_MIN together with an increment.
        cyc(0, 1, 0, 8'h00, 8'h00);
        cyc(0, 1, 0, 8'h00, 8'h00);
        chk("pre_rst_mode", {5'b0, MODE}, 7'd2);
        cyc(1, 0, 1, 8'h00, 8'h00);
        chk("rst_mid_set", dut_vec(), 7'b0000000);
        wait_ce_sec(n);
        chk("rst_restart", 7'(n), 7'(DIV));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 1) == 0) ? 8'h59 : rnd_bcd60(),
                ($urandom_range(0, 1) == 0) ? 8'h59 : rnd_bcd60());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
